// File: rtl/zbuf_sram_ctrl.sv
// Pixel-write responder: buffers rasterizer pixels, z-tests them against a packed
// 2-bit depth region of the shared SRAM, and sweeps that region on a depth clear.
module zbuf_sram_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [17:0] ZBASE      = 18'd76800,
    parameter int          ZWORDS     = 9600
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iPIX_WRITE,
    input  logic [17:0] iPIX_ADDR,
    input  logic [15:0] iPIX_COLOR,
    input  logic [1:0]  iPIX_DEPTH,
    input  logic        iZCLEAR,
    input  logic        iVIDEO_ON,
    output logic [17:0] oSRAM_ADDR,
    output logic [15:0] oSRAM_DQ,
    input  logic [15:0] iSRAM_DQ,
    output logic        oSRAM_WE,
    output logic        oSRAM_OE,
    output logic        oFIFO_FULL,
    output logic        oBUSY,
    output logic        oCLR_BUSY,
    output logic [15:0] oDROP_CNT,
    output logic [15:0] oREJECT_CNT
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (ZWORDS > 1) ? $clog2(ZWORDS) : 1;
    localparam int EW = 18 + 16 + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_Z,
        S_CMP,
        S_WR_C,
        S_WR_Z,
        S_CLR
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [EW-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    logic [17:0]   r_pix_addr;
    logic [15:0]   r_pix_color;
    logic [1:0]    r_pix_depth;
    logic [15:0]   r_zword;

    logic          r_clr_pend;
    logic [CW-1:0] r_clr_idx;
    logic [CW-1:0] w_clr_idx_next;
    logic          w_clr_enter;

    logic [17:0]   r_sram_addr;
    logic [17:0]   w_sram_addr;
    logic [15:0]   r_sram_dq;
    logic [15:0]   w_sram_dq;
    logic          w_we;
    logic          w_oe;
    logic          w_reject;
    logic          w_zcap;

    logic [15:0]   r_drop_cnt;
    logic [15:0]   r_reject_cnt;

    logic [17:0]   w_zaddr;
    logic [1:0]    w_stored_depth;
    logic [15:0]   w_zmerged;

    // ---------------- pixel FIFO ----------------
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = iPIX_WRITE && !w_full;

    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {iPIX_ADDR, iPIX_COLOR, iPIX_DEPTH};
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // ---------------- depth word addressing ----------------
    assign w_zaddr        = ZBASE + {3'b000, r_pix_addr[17:3]};
    assign w_stored_depth = iSRAM_DQ[{r_pix_addr[2:0], 1'b0} +: 2];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            assign w_zmerged[2*gi+1:2*gi] = (r_pix_addr[2:0] == 3'(gi)) ?
                                            r_pix_depth : r_zword[2*gi+1:2*gi];
        end
    endgenerate

    // ---------------- FSM ----------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= S_IDLE;
            r_clr_idx   <= '0;
            r_sram_addr <= '0;
            r_sram_dq   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clr_idx   <= w_clr_idx_next;
            r_sram_addr <= w_sram_addr;
            r_sram_dq   <= w_sram_dq;
        end
    end

    // Address/data hold their last value outside active access states, so a
    // video stall leaves the bus unchanged.
    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_sram_addr    = r_sram_addr;
        w_sram_dq      = r_sram_dq;
        w_we           = 1'b0;
        w_oe           = 1'b0;
        w_pop          = 1'b0;
        w_clr_enter    = 1'b0;
        w_reject       = 1'b0;
        w_zcap         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_clr_pend) begin
                    w_clr_enter    = 1'b1;
                    w_clr_idx_next = '0;
                    w_state_next   = S_CLR;
                end else if (!w_empty && !iVIDEO_ON) begin
                    w_pop        = 1'b1;
                    w_state_next = S_RD_Z;
                end
            end
            S_RD_Z: begin
                w_sram_addr = w_zaddr;
                if (!iVIDEO_ON) begin
                    w_oe         = 1'b1;
                    w_state_next = S_CMP;
                end
            end
            S_CMP: begin
                w_zcap = 1'b1;
                if (r_pix_depth <= w_stored_depth) begin
                    w_state_next = S_WR_C;
                end else begin
                    w_reject     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WR_C: begin
                w_sram_addr = r_pix_addr;
                w_sram_dq   = r_pix_color;
                if (!iVIDEO_ON) begin
                    w_we         = 1'b1;
                    w_state_next = S_WR_Z;
                end
            end
            S_WR_Z: begin
                w_sram_addr = w_zaddr;
                w_sram_dq   = w_zmerged;
                if (!iVIDEO_ON) begin
                    w_we         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_CLR: begin
                w_sram_addr = ZBASE + 18'(r_clr_idx);
                w_sram_dq   = 16'hFFFF;
                if (!iVIDEO_ON) begin
                    w_we = 1'b1;
                    if (r_clr_idx == CW'(ZWORDS - 1)) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_clr_idx_next = r_clr_idx + CW'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- pixel latch, clear request, counters ----------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_pix_addr  <= '0;
            r_pix_color <= '0;
            r_pix_depth <= '0;
            r_zword     <= '0;
        end else begin
            if (w_pop) begin
                {r_pix_addr, r_pix_color, r_pix_depth} <= r_fifo_mem[r_rd_ptr];
            end
            if (w_zcap) begin
                r_zword <= iSRAM_DQ;
            end
        end
    end

    // A request arriving on the entry cycle still wins, so it re-runs the sweep.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_clr_pend <= 1'b0;
        end else if (iZCLEAR) begin
            r_clr_pend <= 1'b1;
        end else if (w_clr_enter) begin
            r_clr_pend <= 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_drop_cnt   <= '0;
            r_reject_cnt <= '0;
        end else begin
            if (iPIX_WRITE && w_full) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_reject) begin
                r_reject_cnt <= r_reject_cnt + 16'd1;
            end
        end
    end

    assign oSRAM_ADDR  = w_sram_addr;
    assign oSRAM_DQ    = w_sram_dq;
    assign oSRAM_WE    = w_we;
    assign oSRAM_OE    = w_oe;
    assign oFIFO_FULL  = w_full;
    assign oBUSY       = (r_state != S_IDLE) || !w_empty;
    assign oCLR_BUSY   = (r_state == S_CLR);
    assign oDROP_CNT   = r_drop_cnt;
    assign oREJECT_CNT = r_reject_cnt;

endmodule

// File: tb/tb_zbuf_sram_ctrl.sv
// Directed bench for zbuf_sram_ctrl with a behavioural SRAM (read data one cycle
// after OE) and a log of colour-plane writes.
module tb_zbuf_sram_ctrl;
    localparam logic [17:0] ZBASE = 18'd76800;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iPIX_WRITE;
    logic [17:0] iPIX_ADDR;
    logic [15:0] iPIX_COLOR;
    logic [1:0]  iPIX_DEPTH;
    logic        iZCLEAR;
    logic        iVIDEO_ON;
    logic [17:0] oSRAM_ADDR;
    logic [15:0] oSRAM_DQ;
    logic [15:0] iSRAM_DQ;
    logic        oSRAM_WE;
    logic        oSRAM_OE;
    logic        oFIFO_FULL;
    logic        oBUSY;
    logic        oCLR_BUSY;
    logic [15:0] oDROP_CNT;
    logic [15:0] oREJECT_CNT;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:262143];
    logic [15:0] rd_q = 16'h0;
    logic [17:0] log_addr [$];
    logic [15:0] log_data [$];

    zbuf_sram_ctrl #(.FIFO_DEPTH(8), .ZBASE(18'd76800), .ZWORDS(9600)) dut (
        .iCLK(iCLK), .iRST(iRST), .iPIX_WRITE(iPIX_WRITE), .iPIX_ADDR(iPIX_ADDR),
        .iPIX_COLOR(iPIX_COLOR), .iPIX_DEPTH(iPIX_DEPTH), .iZCLEAR(iZCLEAR),
        .iVIDEO_ON(iVIDEO_ON), .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_DQ(oSRAM_DQ),
        .iSRAM_DQ(iSRAM_DQ), .oSRAM_WE(oSRAM_WE), .oSRAM_OE(oSRAM_OE),
        .oFIFO_FULL(oFIFO_FULL), .oBUSY(oBUSY), .oCLR_BUSY(oCLR_BUSY),
        .oDROP_CNT(oDROP_CNT), .oREJECT_CNT(oREJECT_CNT)
    );

    always #5 iCLK = ~iCLK;

    assign iSRAM_DQ = rd_q;

    always @(posedge iCLK) begin
        if (oSRAM_WE) begin
            mem[oSRAM_ADDR] <= oSRAM_DQ;
            if (oSRAM_ADDR < ZBASE) begin
                log_addr.push_back(oSRAM_ADDR);
                log_data.push_back(oSRAM_DQ);
            end
        end
        if (oSRAM_OE) begin
            rd_q <= mem[oSRAM_ADDR];
        end
    end

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_pix(input logic w, input logic [17:0] a, input logic [15:0] c,
                           input logic [1:0] d);
        iPIX_WRITE = w;
        iPIX_ADDR  = a;
        iPIX_COLOR = c;
        iPIX_DEPTH = d;
    endtask

    // Returns one step after the capturing edge, FSM still idle with one entry queued.
    task automatic push(input logic [17:0] a, input logic [15:0] c, input logic [1:0] d);
        set_pix(1'b1, a, c, d);
        cyc();
        set_pix(1'b0, 18'd0, 16'd0, 2'd0);
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        iZCLEAR = 1'b0;
        iVIDEO_ON = 1'b0;
        set_pix(1'b0, 18'd0, 16'd0, 2'd0);
        cyc();
        cyc();
        iRST = 1'b0;
        #1;
        checks++;
        if ({oSRAM_WE, oSRAM_OE, oSRAM_ADDR, oSRAM_DQ} !== 36'd0) begin
            errors++;
            $display("FAIL reset_bus: we=%b oe=%b addr=%0d dq=%h, want all 0",
                     oSRAM_WE, oSRAM_OE, oSRAM_ADDR, oSRAM_DQ);
        end
        checks++;
        if ({oFIFO_FULL, oBUSY, oCLR_BUSY, oDROP_CNT, oREJECT_CNT} !== 35'd0) begin
            errors++;
            $display("FAIL reset_status: full=%b busy=%b clr=%b drop=%0d rej=%0d, want all 0",
                     oFIFO_FULL, oBUSY, oCLR_BUSY, oDROP_CNT, oREJECT_CNT);
        end
    endtask

    task automatic test_clear();
        int n;
        int bad;
        n = 0;
        bad = 0;
        iZCLEAR = 1'b1;
        cyc();
        iZCLEAR = 1'b0;
        cyc();
        while (oCLR_BUSY === 1'b1 && n < 20000) begin
            if (oSRAM_WE !== 1'b1 || oSRAM_OE !== 1'b0 || oSRAM_ADDR !== ZBASE + 18'(n) ||
                oSRAM_DQ !== 16'hFFFF) begin
                if (bad == 0) begin
                    $display("FAIL clear_word: step %0d we=%b oe=%b addr=%0d dq=%h, want we=1 oe=0 addr=%0d dq=ffff",
                             n, oSRAM_WE, oSRAM_OE, oSRAM_ADDR, oSRAM_DQ, ZBASE + 18'(n));
                end
                bad++;
            end
            n++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_words: %0d bad sweep cycles, want 0", bad);
        end
        checks++;
        if (n != 9600) begin
            errors++;
            $display("FAIL clear_length: clr_busy for %0d cycles, want 9600", n);
        end
        checks++;
        if (oBUSY !== 1'b0 || mem[18'd86399] !== 16'hFFFF) begin
            errors++;
            $display("FAIL clear_end: busy=%b last_word=%h, want busy=0 last_word=ffff",
                     oBUSY, mem[18'd86399]);
        end
    endtask

    task automatic test_pixel_pass();
        push(18'd100, 16'h0F00, 2'd0);
        cyc();
        checks++;
        if (oSRAM_OE !== 1'b1 || oSRAM_WE !== 1'b0 || oSRAM_ADDR !== 18'd76812) begin
            errors++;
            $display("FAIL pass_rd_z: oe=%b we=%b addr=%0d, want oe=1 we=0 addr=76812",
                     oSRAM_OE, oSRAM_WE, oSRAM_ADDR);
        end
        cyc();
        checks++;
        if (oSRAM_OE !== 1'b0 || oSRAM_WE !== 1'b0) begin
            errors++;
            $display("FAIL pass_cmp: oe=%b we=%b, want both 0", oSRAM_OE, oSRAM_WE);
        end
        cyc();
        checks++;
        if (oSRAM_WE !== 1'b1 || oSRAM_ADDR !== 18'd100 || oSRAM_DQ !== 16'h0F00) begin
            errors++;
            $display("FAIL pass_wr_c: we=%b addr=%0d dq=%h, want we=1 addr=100 dq=0f00",
                     oSRAM_WE, oSRAM_ADDR, oSRAM_DQ);
        end
        cyc();
        checks++;
        if (oSRAM_WE !== 1'b1 || oSRAM_ADDR !== 18'd76812 || oSRAM_DQ !== 16'hFCFF) begin
            errors++;
            $display("FAIL pass_wr_z: we=%b addr=%0d dq=%h, want we=1 addr=76812 dq=fcff",
                     oSRAM_WE, oSRAM_ADDR, oSRAM_DQ);
        end
        cyc();
        checks++;
        if (oSRAM_WE !== 1'b0 || oBUSY !== 1'b0 || mem[18'd100] !== 16'h0F00) begin
            errors++;
            $display("FAIL pass_done: we=%b busy=%b mem100=%h, want we=0 busy=0 mem100=0f00",
                     oSRAM_WE, oBUSY, mem[18'd100]);
        end
    endtask

    task automatic test_ztest();
        int we_seen;
        push(18'd101, 16'h1111, 2'd1);
        repeat (5) cyc();
        checks++;
        if (mem[18'd76812] !== 16'hF4FF || mem[18'd101] !== 16'h1111) begin
            errors++;
            $display("FAIL ztest_first: zword=%h color=%h, want f4ff 1111",
                     mem[18'd76812], mem[18'd101]);
        end
        push(18'd101, 16'h2222, 2'd2);
        we_seen = 0;
        repeat (5) begin
            if (oSRAM_WE === 1'b1) we_seen++;
            cyc();
        end
        checks++;
        if (we_seen != 0 || oREJECT_CNT !== 16'd1 || mem[18'd101] !== 16'h1111) begin
            errors++;
            $display("FAIL ztest_reject: we_cycles=%0d rej=%0d color=%h, want 0 1 1111",
                     we_seen, oREJECT_CNT, mem[18'd101]);
        end
        push(18'd101, 16'h3333, 2'd1);
        repeat (5) cyc();
        checks++;
        if (mem[18'd101] !== 16'h3333 || mem[18'd76812] !== 16'hF4FF || oREJECT_CNT !== 16'd1) begin
            errors++;
            $display("FAIL ztest_equal: color=%h zword=%h rej=%0d, want 3333 f4ff 1",
                     mem[18'd101], mem[18'd76812], oREJECT_CNT);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int bad;
        log_addr.delete();
        log_data.delete();
        push(18'd1000, 16'hA000, 2'd0);
        set_pix(1'b1, 18'd1008, 16'hA001, 2'd0);
        cyc();
        iVIDEO_ON = 1'b1;
        for (int i = 2; i < 12; i++) begin
            set_pix(1'b1, 18'd1000 + 18'(8 * i), 16'hA000 + 16'(i), 2'd0);
            cyc();
        end
        set_pix(1'b0, 18'd0, 16'd0, 2'd0);
        #1;
        checks++;
        if (oFIFO_FULL !== 1'b1 || oDROP_CNT !== 16'd3) begin
            errors++;
            $display("FAIL b2b_full: full=%b drop=%0d, want full=1 drop=3", oFIFO_FULL, oDROP_CNT);
        end
        iVIDEO_ON = 1'b0;
        n = 0;
        while (oBUSY === 1'b1 && n < 300) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL b2b_drain: still busy after %0d cycles, want idle", n);
        end
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (i >= log_addr.size() || log_addr[i] !== 18'd1000 + 18'(8 * i) ||
                log_data[i] !== 16'hA000 + 16'(i)) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0 || log_addr.size() != 9) begin
            errors++;
            $display("FAIL b2b_order: %0d bad entries, %0d colour writes, want 0 bad and 9 writes",
                     bad, log_addr.size());
        end
        checks++;
        if (mem[18'd76925] !== 16'hFFFC || mem[18'd76933] !== 16'hFFFC) begin
            errors++;
            $display("FAIL b2b_depth: first=%h last=%h, want fffc fffc",
                     mem[18'd76925], mem[18'd76933]);
        end
    endtask

    task automatic test_video();
        int bad;
        push(18'd200, 16'hBEEF, 2'd2);
        cyc();
        cyc();
        cyc();
        iVIDEO_ON = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (oSRAM_WE !== 1'b0 || oSRAM_OE !== 1'b0 || oSRAM_ADDR !== 18'd200) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL video_hold: %0d cycles with strobe or moved address, want 0", bad);
        end
        iVIDEO_ON = 1'b0;
        #1;
        checks++;
        if (oSRAM_WE !== 1'b1 || oSRAM_ADDR !== 18'd200 || oSRAM_DQ !== 16'hBEEF) begin
            errors++;
            $display("FAIL video_resume: we=%b addr=%0d dq=%h, want we=1 addr=200 dq=beef",
                     oSRAM_WE, oSRAM_ADDR, oSRAM_DQ);
        end
        cyc();
        cyc();
        push(18'd208, 16'hBEEF, 2'd2);
        repeat (6) cyc();
        checks++;
        if (mem[18'd200] !== 16'hBEEF || mem[18'd76825] !== 16'hFFFE ||
            mem[18'd208] !== 16'hBEEF || mem[18'd76826] !== 16'hFFFE) begin
            errors++;
            $display("FAIL video_result: stalled %h/%h plain %h/%h, want beef/fffe both",
                     mem[18'd200], mem[18'd76825], mem[18'd208], mem[18'd76826]);
        end
    endtask

    task automatic test_reset_mid();
        set_pix(1'b1, 18'd300, 16'h5555, 2'd0);
        cyc();
        set_pix(1'b1, 18'd308, 16'h6666, 2'd0);
        cyc();
        set_pix(1'b0, 18'd0, 16'd0, 2'd0);
        cyc();
        cyc();
        checks++;
        if (oSRAM_WE !== 1'b1 || oSRAM_ADDR !== 18'd300) begin
            errors++;
            $display("FAIL rst_setup: we=%b addr=%0d, want we=1 addr=300", oSRAM_WE, oSRAM_ADDR);
        end
        iRST = 1'b1;
        cyc();
        iRST = 1'b0;
        #1;
        checks++;
        if (oSRAM_WE !== 1'b0 || oSRAM_OE !== 1'b0 || oBUSY !== 1'b0 || oFIFO_FULL !== 1'b0 ||
            oDROP_CNT !== 16'd0 || oREJECT_CNT !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: we=%b oe=%b busy=%b full=%b drop=%0d rej=%0d, want all 0",
                     oSRAM_WE, oSRAM_OE, oBUSY, oFIFO_FULL, oDROP_CNT, oREJECT_CNT);
        end
        push(18'd316, 16'h7777, 2'd0);
        repeat (6) cyc();
        checks++;
        if (mem[18'd316] !== 16'h7777 || mem[18'd76839] !== 16'hFCFF || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: color=%h zword=%h busy=%b, want 7777 fcff 0",
                     mem[18'd316], mem[18'd76839], oBUSY);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear();
        test_pixel_pass();
        test_ztest();
        test_back_to_back();
        test_video();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
